// File: rtl/pixel_scheduler.sv
// pixel_scheduler: walks the frame in raster order and issues one pixel
// coordinate per ray request, throttled by a credit counter that tracer
// completion pulses replenish. Reports frame completion and counts frames.
module pixel_scheduler #(
    parameter int WIDTH        = 1280,
    parameter int HEIGHT       = 720,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        continuous,
    input  logic        ray_ready,
    input  logic        ray_done,
    output logic [10:0] pixel_h_out,
    output logic [9:0]  pixel_v_out,
    output logic        new_ray,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic [3:0]  inflight
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [10:0] h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [10:0] pixel_h_q, pixel_h_d;
    logic [9:0]  pixel_v_q, pixel_v_d;
    logic        new_ray_q, new_ray_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [3:0]  inflight_q, inflight_d;
    logic        issue;

    // Next-state, raster counters, credit accounting and registered outputs
    always_comb begin
        state_d       = state_q;
        h_d           = h_q;
        v_d           = v_q;
        pixel_h_d     = pixel_h_q;
        pixel_v_d     = pixel_v_q;
        new_ray_d     = 1'b0;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        inflight_d    = inflight_q;

        // Credit check looks only at the registered count, so a same-cycle
        // ray_done can never push issue past the limit.
        issue = (state_q == S_ISSUE) && ray_ready &&
                (inflight_q < 4'(MAX_INFLIGHT));

        case ({issue, ray_done})
            2'b10:   inflight_d = inflight_q + 4'd1;
            2'b01:   if (inflight_q != 4'd0) inflight_d = inflight_q - 4'd1;
            default: inflight_d = inflight_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_ISSUE;
                    h_d     = '0;
                    v_d     = '0;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    new_ray_d = 1'b1;
                    pixel_h_d = h_q;
                    pixel_v_d = v_q;
                    if (h_q == 11'(WIDTH - 1)) begin
                        h_d = '0;
                        if (v_q == 10'(HEIGHT - 1)) begin
                            v_d     = '0;
                            state_d = S_DRAIN;
                        end else begin
                            v_d = v_q + 10'd1;
                        end
                    end else begin
                        h_d = h_q + 11'd1;
                    end
                end
            end
            S_DRAIN: begin
                // Finish as soon as the last credit is back, counting a
                // ray_done that lands this very cycle.
                if (inflight_d == 4'd0) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    h_d           = '0;
                    v_d           = '0;
                    state_d       = continuous ? S_ISSUE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any frame in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            h_q           <= '0;
            v_q           <= '0;
            pixel_h_q     <= '0;
            pixel_v_q     <= '0;
            new_ray_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            inflight_q    <= '0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            pixel_h_q     <= pixel_h_d;
            pixel_v_q     <= pixel_v_d;
            new_ray_q     <= new_ray_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            inflight_q    <= inflight_d;
        end
    end

    assign pixel_h_out = pixel_h_q;
    assign pixel_v_out = pixel_v_q;
    assign new_ray     = new_ray_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign inflight    = inflight_q;

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed bench for pixel_scheduler: a 4x2 frame with 8 credits (dut_a)
// and with 2 credits (dut_b), both driven from the same stimulus.
module tb_pixel_scheduler;

    logic clk, rst, frame_start, continuous, ray_ready, ray_done;

    logic [10:0] ph_a, ph_b;
    logic [9:0]  pv_a, pv_b;
    logic        nr_a, nr_b, busy_a, busy_b, fd_a, fd_b;
    logic [15:0] fc_a, fc_b;
    logic [3:0]  inf_a, inf_b;

    int checks   = 0;
    int failures = 0;

    pixel_scheduler #(.WIDTH(4), .HEIGHT(2), .MAX_INFLIGHT(8)) dut_a (
        .clk(clk), .rst(rst), .frame_start(frame_start), .continuous(continuous),
        .ray_ready(ray_ready), .ray_done(ray_done),
        .pixel_h_out(ph_a), .pixel_v_out(pv_a), .new_ray(nr_a), .busy(busy_a),
        .frame_done(fd_a), .frame_count(fc_a), .inflight(inf_a)
    );

    pixel_scheduler #(.WIDTH(4), .HEIGHT(2), .MAX_INFLIGHT(2)) dut_b (
        .clk(clk), .rst(rst), .frame_start(frame_start), .continuous(continuous),
        .ray_ready(ray_ready), .ray_done(ray_done),
        .pixel_h_out(ph_b), .pixel_v_out(pv_b), .new_ray(nr_b), .busy(busy_b),
        .frame_done(fd_b), .frame_count(fc_b), .inflight(inf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle; outputs are observed 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; frame_start = 1'b0; continuous = 1'b0;
        ray_ready = 1'b0; ray_done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_start = 1'b0; continuous = 1'b0;
        ray_ready = 1'b0; ray_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({ph_a, pv_a, nr_a, busy_a, fd_a, fc_a, inf_a} !== 45'd0) begin
            failures++;
            $display("FAIL reset_a outputs=%h expected 0", {ph_a, pv_a, nr_a, busy_a, fd_a, fc_a, inf_a});
        end
        checks++;
        if ({ph_b, pv_b, nr_b, busy_b, fd_b, fc_b, inf_b} !== 45'd0) begin
            failures++;
            $display("FAIL reset_b outputs=%h expected 0", {ph_b, pv_b, nr_b, busy_b, fd_b, fc_b, inf_b});
        end
        tick();
        checks++;
        if ({nr_a, busy_a, inf_a} !== 6'd0) begin
            failures++;
            $display("FAIL idle_hold got=%h expected 0", {nr_a, busy_a, inf_a});
        end
    endtask

    // Single frame, ready always high, each ray completes 3 cycles after issue
    task automatic test_frame();
        logic [2:0] d;
        int k, fd_n, fd_cyc;
        do_reset();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        ray_ready = 1'b1; d = '0; k = 0; fd_n = 0; fd_cyc = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            if (nr_a) begin
                checks++;
                if (ph_a !== 11'(k % 4) || pv_a !== 10'(k / 4) || cyc != k + 1) begin
                    failures++;
                    $display("FAIL frame_ray%0d got (%0d,%0d)@%0d expected (%0d,%0d)@%0d",
                             k, ph_a, pv_a, cyc, k % 4, k / 4, k + 1);
                end
                k++;
            end
            if (fd_a) begin
                fd_n++; fd_cyc = cyc;
                checks++;
                if (nr_a !== 1'b0) begin
                    failures++;
                    $display("FAIL frame_done_with_new_ray got new_ray=%b expected 0", nr_a);
                end
            end
            d = {d[1:0], nr_a};
            ray_done = d[2];
        end
        ray_ready = 1'b0; ray_done = 1'b0;
        checks++;
        if (k != 8) begin failures++; $display("FAIL frame_ray_count got %0d expected 8", k); end
        checks++;
        if (fd_n != 1 || fd_cyc != 11) begin
            failures++;
            $display("FAIL frame_done_timing got n=%0d cyc=%0d expected n=1 cyc=11", fd_n, fd_cyc);
        end
        checks++;
        if (fc_a !== 16'd1 || busy_a !== 1'b0 || inf_a !== 4'd0) begin
            failures++;
            $display("FAIL frame_end got count=%0d busy=%b inflight=%0d expected 1 0 0", fc_a, busy_a, inf_a);
        end
    endtask

    // Two credits, no completions: stall, then one credit back
    task automatic test_credit_stall();
        int n;
        do_reset();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        ray_ready = 1'b1; n = 0;
        repeat (6) begin tick(); if (nr_b) n++; end
        checks++;
        if (n != 2 || inf_b !== 4'd2) begin
            failures++;
            $display("FAIL stall got rays=%0d inflight=%0d expected 2 2", n, inf_b);
        end
        ray_done = 1'b1; tick(); ray_done = 1'b0;
        checks++;
        if (nr_b !== 1'b0 || inf_b !== 4'd1) begin
            failures++;
            $display("FAIL credit_return got new_ray=%b inflight=%0d expected 0 1", nr_b, inf_b);
        end
        tick();
        checks++;
        if (nr_b !== 1'b1 || ph_b !== 11'd2 || pv_b !== 10'd0 || inf_b !== 4'd2) begin
            failures++;
            $display("FAIL resume got nr=%b (%0d,%0d) inf=%0d expected 1 (2,0) 2", nr_b, ph_b, pv_b, inf_b);
        end
        n = 0;
        repeat (3) begin tick(); if (nr_b) n++; end
        checks++;
        if (n != 0) begin failures++; $display("FAIL restall got rays=%0d expected 0", n); end
        ray_ready = 1'b0;
    endtask

    // ray_ready pattern: a ray follows each ready cycle, coordinates in order
    task automatic test_ready_toggle();
        logic pat [8];
        int k, eh;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        k = 0; eh = 0;
        for (int i = 0; i < 8; i++) begin
            ray_ready = pat[i];
            tick();
            if (pat[i]) begin eh = k; k++; end
            checks++;
            if (nr_a !== pat[i] || ph_a !== 11'(eh) || pv_a !== 10'd0) begin
                failures++;
                $display("FAIL ready_toggle%0d got nr=%b (%0d,%0d) expected nr=%b (%0d,0)",
                         i, nr_a, ph_a, pv_a, pat[i], eh);
            end
        end
        ray_ready = 1'b0;
    endtask

    // Back-to-back frames via continuous; a stray frame_start mid-frame
    task automatic test_continuous();
        logic [2:0] d;
        int k, frames, last_fd;
        do_reset();
        continuous = 1'b1;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        ray_ready = 1'b1; d = '0; k = 0; frames = 0; last_fd = -10;
        for (int cyc = 1; cyc <= 80 && frames < 3; cyc++) begin
            tick();
            if (nr_a) begin
                checks++;
                if (ph_a !== 11'(k % 4) || pv_a !== 10'(k / 4) ||
                    (k == 0 && frames > 0 && cyc != last_fd + 1)) begin
                    failures++;
                    $display("FAIL cont_ray f%0d k%0d got (%0d,%0d)@%0d expected (%0d,%0d)",
                             frames, k, ph_a, pv_a, cyc, k % 4, k / 4);
                end
                k++;
            end
            if (fd_a) begin
                frames++;
                checks++;
                if (fc_a !== 16'(frames) || k != 8 || busy_a !== (frames < 3)) begin
                    failures++;
                    $display("FAIL cont_frame%0d got count=%0d rays=%0d busy=%b expected %0d 8 %b",
                             frames, fc_a, k, busy_a, frames, frames < 3);
                end
                k = 0; last_fd = cyc;
                if (frames == 2) continuous = 1'b0;
            end
            frame_start = (cyc == 5);
            d = {d[1:0], nr_a};
            ray_done = d[2];
        end
        frame_start = 1'b0; continuous = 1'b0; ray_ready = 1'b0; ray_done = 1'b0;
        checks++;
        if (frames != 3) begin failures++; $display("FAIL cont_timeout got frames=%0d expected 3", frames); end
    endtask

    // Reset mid-frame with three rays outstanding
    task automatic test_reset_midframe();
        int flag;
        do_reset();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        ray_ready = 1'b1;
        repeat (3) tick();
        ray_ready = 1'b0; tick();
        checks++;
        if (inf_a !== 4'd3 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL midframe_setup got inflight=%0d busy=%b expected 3 1", inf_a, busy_a);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if ({ph_a, pv_a, nr_a, busy_a, fd_a, fc_a, inf_a} !== 45'd0) begin
            failures++;
            $display("FAIL midframe_reset outputs=%h expected 0", {ph_a, pv_a, nr_a, busy_a, fd_a, fc_a, inf_a});
        end
        ray_ready = 1'b1; flag = 0;
        repeat (4) begin tick(); if (fd_a || nr_a || busy_a) flag++; end
        checks++;
        if (flag != 0) begin failures++; $display("FAIL post_reset_idle got activity=%0d expected 0", flag); end
        ray_ready = 1'b0; ray_done = 1'b1; tick(); ray_done = 1'b0;
        checks++;
        if (inf_a !== 4'd0) begin failures++; $display("FAIL spurious_done got inflight=%0d expected 0", inf_a); end
    endtask

    // Simultaneous issue/done, limit with same-cycle done, underflow guard
    task automatic test_credit_edge();
        do_reset();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        ray_ready = 1'b1; tick();
        checks++;
        if (nr_b !== 1'b1 || inf_b !== 4'd1) begin
            failures++;
            $display("FAIL edge_first got nr=%b inflight=%0d expected 1 1", nr_b, inf_b);
        end
        ray_done = 1'b1; tick();
        checks++;
        if (nr_b !== 1'b1 || ph_b !== 11'd1 || inf_b !== 4'd1) begin
            failures++;
            $display("FAIL issue_and_done got nr=%b h=%0d inflight=%0d expected 1 1 1", nr_b, ph_b, inf_b);
        end
        ray_done = 1'b0; tick();
        checks++;
        if (nr_b !== 1'b1 || inf_b !== 4'd2) begin
            failures++;
            $display("FAIL fill got nr=%b inflight=%0d expected 1 2", nr_b, inf_b);
        end
        ray_done = 1'b1; tick();
        checks++;
        if (nr_b !== 1'b0 || inf_b !== 4'd1) begin
            failures++;
            $display("FAIL full_with_done got nr=%b inflight=%0d expected 0 1", nr_b, inf_b);
        end
        ray_ready = 1'b0; tick();
        checks++;
        if (inf_b !== 4'd0) begin failures++; $display("FAIL drain_credit got inflight=%0d expected 0", inf_b); end
        tick();
        checks++;
        if (inf_b !== 4'd0) begin failures++; $display("FAIL underflow got inflight=%0d expected 0", inf_b); end
        ray_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_credit_stall();
        test_ready_toggle();
        test_continuous();
        test_reset_midframe();
        test_credit_edge();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
